voice_allocator: RTL and testbench
==================================

VOICE_ALLOCATOR -- requirements
Module: voice_allocator

Interface
REQ-001 Parameter DUR_W, 6, width of note duration in beats.
REQ-002 Parameter ID_W, 6, width of note identifier.
REQ-003 Parameter MIN_DUR, 4, minimum duration in beats loaded into any voice.
REQ-004 Port clk  input  1  single system clock, rising edge.
REQ-005 Port reset  input  1  asynchronous, active-low reset.
REQ-006 Port play_enable  input  1  global run; low = pause.
REQ-007 Port beat  input  1  one-cycle pulse at 48 Hz.
REQ-008 Port minibeat  input  1  one-cycle pulse at 192 Hz, coincident with beat every 4th pulse.
REQ-009 Port note_valid  input  1  note request present.
REQ-010 Port note_ready  output  1  request accepted when note_valid && note_ready at a rising edge.
REQ-011 Port note_id  input  ID_W  note identifier of request.
REQ-012 Port note_duration  input  DUR_W  requested duration in beats.
REQ-013 Port voice_play_enable  output  4  per-voice play enable to the dynamics voice.
REQ-014 Port voice_start  output  4  one-cycle pulse when a voice is (re)loaded.
REQ-015 Port voice_note  output  4*ID_W  packed note id per voice; voice i at bits [i*ID_W +: ID_W].
REQ-016 Port voice_duration  output  4*DUR_W  packed loaded duration per voice; same packing.
REQ-017 Port steal  output  1  one-cycle pulse when an active voice is pre-empted.
REQ-018 Port active_count  output  3  number of voices in ACTIVE or MUTE.

Function
REQ-019 Each voice SHALL hold state FREE, ACTIVE or MUTE, a DUR_W-bit remaining counter and an 8-bit age counter.
REQ-020 Allocator FSM SHALL have states IDLE, STEAL_WAIT, ASSIGN.
REQ-021 note_ready SHALL be 1 only in IDLE with play_enable=1.
REQ-022 IDLE, on accept: latch note_id and max(note_duration, MIN_DUR); if any voice FREE, target = lowest-index FREE voice and go to ASSIGN.
REQ-023 IDLE, on accept with no FREE voice: target = voice with largest age (tie -> lowest index); set target to MUTE; pulse steal for one cycle; go to STEAL_WAIT.
REQ-024 STEAL_WAIT SHALL go to ASSIGN on the first minibeat with play_enable=1, never on the acceptance cycle itself.
REQ-025 ASSIGN SHALL last one cycle: load target with ACTIVE, remaining = latched duration, age = 0, voice_note/voice_duration = latched values; pulse voice_start[target] in the following cycle; return to IDLE.
REQ-026 Latency: accept at edge k with a free voice -> voice_start and voice_play_enable high in the cycle after edge k+1.
REQ-027 voice_play_enable[i] SHALL equal (state[i]==ACTIVE) && play_enable, registered.
REQ-028 On beat with play_enable=1, each ACTIVE voice SHALL decrement remaining and increment age (age saturates at 255); at remaining 1 -> 0 the voice becomes FREE.
REQ-029 A voice loaded in ASSIGN during a beat cycle SHALL NOT decrement in that cycle.
REQ-030 A voice expiring at the same edge as an accept SHALL NOT be counted FREE for that accept.
REQ-031 play_enable=0 SHALL freeze all counters and the FSM except the in-flight ASSIGN, which completes.
REQ-032 MUTE voices SHALL NOT decrement or age.
REQ-033 voice_note/voice_duration of FREE voices SHALL retain last values.

Reset
REQ-034 reset low SHALL asynchronously force FSM to IDLE, all voices FREE, all counters 0, all outputs 0, and abandon any latched request or steal in progress.
REQ-035 note_ready SHALL first assert in the first cycle after reset release with play_enable=1.

Verification
REQ-036 Reset release, play_enable=1, one note id=5 dur=10 -> voice 0 start pulse, voice_note[0]=5, play_enable[0] high for exactly 10 beats, active_count 1 then 0.
REQ-037 Note dur=1 -> voice_duration=4, voice expires after 4 beats.
REQ-038 Five back-to-back notes dur=40 spaced 2 beats -> voices 0-3 filled, fifth: steal pulse, voice 0 MUTE, reloaded on next minibeat with voice_start[0].
REQ-039 play_enable dropped for 20 beats mid-note dur=8 -> all voice_play_enable 0, note_ready 0, remaining unchanged; note ends 8 active beats total.
REQ-040 Voice 2 expiring at the same edge a request is accepted, others busy -> steal path taken, not voice 2.
REQ-041 reset asserted during STEAL_WAIT -> all outputs 0 immediately; no voice_start after release.

Source files
------------

// File: rtl/voice_allocator_if.sv
// Note request handshake between a sequencer (master) and the voice allocator (slave).
//   note_valid    : request present                       (master -> slave)
//   note_ready    : allocator accepts a request this cycle (slave -> master)
//   note_id       : note identifier of the request        (master -> slave)
//   note_duration : requested duration in beats           (master -> slave)
interface voice_allocator_if #(
  parameter int unsigned ID_W  = 6,
  parameter int unsigned DUR_W = 6
);
  logic             note_valid;
  logic             note_ready;
  logic [ID_W-1:0]  note_id;
  logic [DUR_W-1:0] note_duration;

  modport master (
    output note_valid,
    output note_id,
    output note_duration,
    input  note_ready
  );

  modport slave (
    input  note_valid,
    input  note_id,
    input  note_duration,
    output note_ready
  );
endinterface

// File: rtl/voice_allocator.sv
// Four-voice note allocator: hands incoming notes to the lowest free voice, or
// steals the oldest voice (mute, then reload on the next minibeat) when all
// four are busy. Active voices count down their duration on every beat.
//   clk               : system clock, rising edge
//   reset             : asynchronous active-low reset
//   play_enable       : global run; low freezes counters and the allocator
//   beat / minibeat   : one-cycle timing pulses (48 Hz / 192 Hz)
//   note              : request handshake (slave side)
//   voice_play_enable : per-voice enable, ACTIVE and running
//   voice_start       : one-cycle pulse when a voice is (re)loaded
//   voice_note        : packed note id per voice, voice i at [i*ID_W +: ID_W]
//   voice_duration    : packed loaded duration per voice, same packing
//   steal             : one-cycle pulse when an active voice is pre-empted
//   active_count      : number of voices in ACTIVE or MUTE
module voice_allocator #(
  parameter int unsigned DUR_W   = 6,
  parameter int unsigned ID_W    = 6,
  parameter int unsigned MIN_DUR = 4
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 play_enable,
  input  logic                 beat,
  input  logic                 minibeat,
  voice_allocator_if.slave     note,
  output logic [3:0]           voice_play_enable,
  output logic [3:0]           voice_start,
  output logic [4*ID_W-1:0]    voice_note,
  output logic [4*DUR_W-1:0]   voice_duration,
  output logic                 steal,
  output logic [2:0]           active_count
);

  localparam int unsigned      NV        = 4;
  localparam int unsigned      AGE_W     = 8;
  localparam logic [AGE_W-1:0] AGE_MAX   = {AGE_W{1'b1}};
  localparam logic [DUR_W-1:0] MIN_DUR_V = DUR_W'(MIN_DUR);
  localparam logic [DUR_W-1:0] ONE_BEAT  = DUR_W'(1);

  typedef enum logic [1:0] {IDLE, STEAL_WAIT, ASSIGN} alloc_state_e;
  typedef enum logic [1:0] {V_FREE, V_ACTIVE, V_MUTE} voice_state_e;

  // Allocator state and latched request
  alloc_state_e     state;
  logic             armed;
  logic [1:0]       target;
  logic [ID_W-1:0]  lat_id;
  logic [DUR_W-1:0] lat_dur;

  // Per-voice state
  voice_state_e     v_state [NV];
  logic [DUR_W-1:0] v_rem   [NV];
  logic [AGE_W-1:0] v_age   [NV];

  // Combinational decode
  logic             ready_c;
  logic             accept_c;
  logic             tick_c;
  logic             steal_c;
  logic             any_free_c;
  logic [1:0]       free_idx_c;
  logic [1:0]       old_idx_c;
  logic [AGE_W-1:0] old_age_c;
  logic [DUR_W-1:0] clamp_dur_c;
  logic [NV-1:0]    load_c;
  logic [NV-1:0]    mute_c;
  logic [NV-1:0]    vpe_n;
  logic [2:0]       count_n;
  voice_state_e     v_state_n [NV];

  // armed keeps note_ready low while reset is held and until the first edge after release
  assign ready_c         = armed && play_enable && (state == IDLE);
  assign note.note_ready = ready_c;
  assign accept_c        = ready_c && note.note_valid;
  assign tick_c          = beat && play_enable;
  assign steal_c         = accept_c && !any_free_c;
  assign clamp_dur_c     = (note.note_duration < MIN_DUR_V) ? MIN_DUR_V : note.note_duration;

  // Lowest-index FREE voice and oldest voice (strict > keeps the lowest index on ties).
  // A voice expiring at this edge is still ACTIVE here, so it is never seen as free.
  always_comb begin
    any_free_c = 1'b0;
    free_idx_c = '0;
    old_idx_c  = '0;
    old_age_c  = v_age[0];
    for (int i = 0; i < int'(NV); i++) begin
      if (!any_free_c && (v_state[i] == V_FREE)) begin
        any_free_c = 1'b1;
        free_idx_c = 2'(i);
      end
      if (v_age[i] > old_age_c) begin
        old_age_c = v_age[i];
        old_idx_c = 2'(i);
      end
    end
  end

  // Next voice states: load beats mute beats expiry
  always_comb begin
    count_n = '0;
    for (int i = 0; i < int'(NV); i++) begin
      load_c[i]    = (state == ASSIGN) && (target == 2'(i));
      mute_c[i]    = steal_c && (old_idx_c == 2'(i));
      v_state_n[i] = v_state[i];
      if (load_c[i]) begin
        v_state_n[i] = V_ACTIVE;
      end else if (mute_c[i]) begin
        v_state_n[i] = V_MUTE;
      end else if (tick_c && (v_state[i] == V_ACTIVE) && (v_rem[i] == ONE_BEAT)) begin
        v_state_n[i] = V_FREE;
      end
      vpe_n[i] = (v_state_n[i] == V_ACTIVE) && play_enable;
      count_n  = count_n + 3'(v_state_n[i] != V_FREE);
    end
  end

  // Allocator FSM and its registered outputs
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state             <= IDLE;
      armed             <= 1'b0;
      target            <= '0;
      lat_id            <= '0;
      lat_dur           <= '0;
      steal             <= 1'b0;
      voice_start       <= '0;
      voice_play_enable <= '0;
      active_count      <= '0;
    end else begin
      armed             <= 1'b1;
      steal             <= steal_c;
      voice_start       <= (state == ASSIGN) ? (4'b0001 << target) : 4'b0000;
      voice_play_enable <= vpe_n;
      active_count      <= count_n;
      case (state)
        IDLE: begin
          if (accept_c) begin
            lat_id  <= note.note_id;
            lat_dur <= clamp_dur_c;
            if (any_free_c) begin
              target <= free_idx_c;
              state  <= ASSIGN;
            end else begin
              target <= old_idx_c;
              state  <= STEAL_WAIT;
            end
          end
        end
        STEAL_WAIT: begin
          if (minibeat && play_enable) begin
            state <= ASSIGN;
          end
        end
        ASSIGN: begin
          // Completes even when paused
          state <= IDLE;
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

  // Voice counters and per-voice note/duration registers
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < int'(NV); i++) begin
        v_state[i] <= V_FREE;
        v_rem[i]   <= '0;
        v_age[i]   <= '0;
      end
      voice_note     <= '0;
      voice_duration <= '0;
    end else begin
      for (int i = 0; i < int'(NV); i++) begin
        v_state[i] <= v_state_n[i];
        if (load_c[i]) begin
          v_rem[i]                         <= lat_dur;
          v_age[i]                         <= '0;
          voice_note[i*ID_W +: ID_W]       <= lat_id;
          voice_duration[i*DUR_W +: DUR_W] <= lat_dur;
        end else if (tick_c && (v_state[i] == V_ACTIVE) && !mute_c[i]) begin
          v_rem[i] <= v_rem[i] - ONE_BEAT;
          if (v_age[i] != AGE_MAX) begin
            v_age[i] <= v_age[i] + AGE_W'(1);
          end
        end
      end
    end
  end

endmodule

// File: tb/tb_voice_allocator.sv
// Directed bench for voice_allocator: reset, single note, minimum duration,
// steal on a full pool, pause, expiry colliding with accept, reset mid-steal.
module tb_voice_allocator;

  localparam int unsigned ID_W  = 6;
  localparam int unsigned DUR_W = 6;

  logic               clk;
  logic               reset;
  logic               play_enable;
  logic               beat;
  logic               minibeat;
  logic [3:0]         voice_play_enable;
  logic [3:0]         voice_start;
  logic [4*ID_W-1:0]  voice_note;
  logic [4*DUR_W-1:0] voice_duration;
  logic               steal;
  logic [2:0]         active_count;

  int errors = 0;
  int checks = 0;
  int phase  = 0;
  bit last_beat;

  voice_allocator_if #(.ID_W(ID_W), .DUR_W(DUR_W)) nif ();

  voice_allocator #(.DUR_W(DUR_W), .ID_W(ID_W), .MIN_DUR(4)) dut (
    .clk               (clk),
    .reset             (reset),
    .play_enable       (play_enable),
    .beat              (beat),
    .minibeat          (minibeat),
    .note              (nif),
    .voice_play_enable (voice_play_enable),
    .voice_start       (voice_start),
    .voice_note        (voice_note),
    .voice_duration    (voice_duration),
    .steal             (steal),
    .active_count      (active_count)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #400000;
    $display("FAIL watchdog: simulation did not finish, errors=%0d checks=%0d", errors, checks);
    $fatal(1);
  end

  // One clock: minibeat every 4th cycle, beat every 16th (coincident with a minibeat)
  task automatic step();
    minibeat  = ((phase % 4) == 3);
    beat      = ((phase % 16) == 15);
    last_beat = beat;
    @(posedge clk);
    #1;
    phase++;
  endtask

  task automatic run_beats(input int n);
    int seen;
    seen = 0;
    while (seen < n) begin
      step();
      if (last_beat) seen++;
    end
  endtask

  task automatic do_reset();
    nif.note_valid = 1'b0;
    reset = 1'b0;
    step();
    step();
    reset = 1'b1;
    step();
  endtask

  // Holds a request until it is accepted; returns #1 after the accepting edge
  task automatic send_note(input logic [ID_W-1:0] id, input logic [DUR_W-1:0] dur, output bit ok);
    nif.note_valid    = 1'b1;
    nif.note_id       = id;
    nif.note_duration = dur;
    ok = 1'b0;
    for (int c = 0; c < 200; c++) begin
      if (nif.note_ready === 1'b1) begin
        ok = 1'b1;
        step();
        break;
      end
      step();
    end
    nif.note_valid = 1'b0;
  endtask

  // Counts beat edges while one voice (voice 0) is still active
  task automatic count_active_beats(output int n, output bit vpe_bad, output bit timeout);
    n = 0;
    vpe_bad = 1'b0;
    timeout = 1'b1;
    for (int c = 0; c < 2000; c++) begin
      if (active_count == 3'd0) begin
        timeout = 1'b0;
        break;
      end
      if (voice_play_enable !== 4'b0001) vpe_bad = 1'b1;
      step();
      if (last_beat) n++;
    end
  endtask

  task automatic test_reset();
    reset = 1'b0;
    play_enable = 1'b1;
    step();
    step();
    checks++; if (voice_play_enable !== 4'b0000) begin errors++; $display("FAIL reset_vpe: got %b want 0000", voice_play_enable); end
    checks++; if (voice_start !== 4'b0000) begin errors++; $display("FAIL reset_start: got %b want 0000", voice_start); end
    checks++; if (steal !== 1'b0) begin errors++; $display("FAIL reset_steal: got %b want 0", steal); end
    checks++; if (active_count !== 3'd0) begin errors++; $display("FAIL reset_count: got %0d want 0", active_count); end
    checks++; if (voice_note !== '0 || voice_duration !== '0) begin errors++; $display("FAIL reset_note_dur: got %h/%h want 0/0", voice_note, voice_duration); end
    checks++; if (nif.note_ready !== 1'b0) begin errors++; $display("FAIL reset_ready: got %b want 0", nif.note_ready); end
    reset = 1'b1;
    step();
    checks++; if (nif.note_ready !== 1'b1) begin errors++; $display("FAIL ready_after_release: got %b want 1", nif.note_ready); end
  endtask

  task automatic test_single_note();
    bit ok, bad, to;
    int n;
    send_note(6'd5, 6'd10, ok);
    checks++; if (!ok) begin errors++; $display("FAIL single_accept: got no accept want accept"); end
    checks++; if (voice_start !== 4'b0000) begin errors++; $display("FAIL single_start_early: got %b want 0000", voice_start); end
    step();
    checks++; if (voice_start !== 4'b0001 || voice_play_enable !== 4'b0001) begin errors++; $display("FAIL single_start: got start=%b vpe=%b want 0001/0001", voice_start, voice_play_enable); end
    checks++; if (voice_note[5:0] !== 6'd5 || voice_duration[5:0] !== 6'd10) begin errors++; $display("FAIL single_note_dur: got %0d/%0d want 5/10", voice_note[5:0], voice_duration[5:0]); end
    checks++; if (active_count !== 3'd1) begin errors++; $display("FAIL single_count: got %0d want 1", active_count); end
    step();
    checks++; if (voice_start !== 4'b0000) begin errors++; $display("FAIL single_start_pulse: got %b want 0000", voice_start); end
    count_active_beats(n, bad, to);
    checks++; if (to || n != 10) begin errors++; $display("FAIL single_beats: got %0d (timeout=%0d) want 10", n, to); end
    checks++; if (bad) begin errors++; $display("FAIL single_vpe_hold: got vpe drop want 0001 while active"); end
    checks++; if (voice_play_enable !== 4'b0000 || active_count !== 3'd0) begin errors++; $display("FAIL single_end: got vpe=%b cnt=%0d want 0000/0", voice_play_enable, active_count); end
    checks++; if (voice_note[5:0] !== 6'd5) begin errors++; $display("FAIL single_retain: got %0d want 5", voice_note[5:0]); end
  endtask

  task automatic test_min_duration();
    bit ok, bad, to;
    int n;
    send_note(6'd7, 6'd1, ok);
    step();
    checks++; if (!ok || voice_duration[5:0] !== 6'd4 || voice_note[5:0] !== 6'd7) begin errors++; $display("FAIL min_dur_load: got ok=%0d dur=%0d id=%0d want 1/4/7", ok, voice_duration[5:0], voice_note[5:0]); end
    count_active_beats(n, bad, to);
    checks++; if (to || n != 4) begin errors++; $display("FAIL min_dur_beats: got %0d (timeout=%0d) want 4", n, to); end
  endtask

  task automatic test_steal();
    bit ok;
    bit all_ok;
    int w;
    do_reset();
    all_ok = 1'b1;
    for (int k = 0; k < 4; k++) begin
      send_note(6'(10 + k), 6'd40, ok);
      all_ok &= ok;
      run_beats(2);
    end
    checks++; if (!all_ok || voice_play_enable !== 4'b1111 || active_count !== 3'd4) begin errors++; $display("FAIL steal_fill: got ok=%0d vpe=%b cnt=%0d want 1/1111/4", all_ok, voice_play_enable, active_count); end
    send_note(6'd14, 6'd40, ok);
    checks++; if (!ok || steal !== 1'b1) begin errors++; $display("FAIL steal_pulse: got ok=%0d steal=%b want 1/1", ok, steal); end
    checks++; if (voice_play_enable !== 4'b1110 || active_count !== 3'd4) begin errors++; $display("FAIL steal_mute: got vpe=%b cnt=%0d want 1110/4", voice_play_enable, active_count); end
    step();
    w = 1;
    checks++; if (steal !== 1'b0) begin errors++; $display("FAIL steal_one_cycle: got %b want 0", steal); end
    while (voice_start === 4'b0000 && w < 20) begin
      step();
      w++;
    end
    checks++; if (w < 2 || w > 5) begin errors++; $display("FAIL steal_latency: got %0d cycles want 2..5", w); end
    checks++; if (voice_start !== 4'b0001 || voice_note[5:0] !== 6'd14 || voice_duration[5:0] !== 6'd40) begin errors++; $display("FAIL steal_reload: got start=%b id=%0d dur=%0d want 0001/14/40", voice_start, voice_note[5:0], voice_duration[5:0]); end
    checks++; if (voice_play_enable !== 4'b1111) begin errors++; $display("FAIL steal_vpe_after: got %b want 1111", voice_play_enable); end
  endtask

  task automatic test_pause();
    bit ok, bad, to, pbad;
    int n, seen;
    do_reset();
    send_note(6'd20, 6'd8, ok);
    step();
    checks++; if (!ok || voice_play_enable !== 4'b0001) begin errors++; $display("FAIL pause_load: got ok=%0d vpe=%b want 1/0001", ok, voice_play_enable); end
    run_beats(3);
    play_enable = 1'b0;
    step();
    checks++; if (voice_play_enable !== 4'b0000 || nif.note_ready !== 1'b0) begin errors++; $display("FAIL pause_outputs: got vpe=%b ready=%b want 0000/0", voice_play_enable, nif.note_ready); end
    pbad = 1'b0;
    seen = 0;
    while (seen < 20) begin
      if (voice_play_enable !== 4'b0000 || nif.note_ready !== 1'b0 || voice_start !== 4'b0000) pbad = 1'b1;
      step();
      if (last_beat) seen++;
    end
    checks++; if (pbad) begin errors++; $display("FAIL pause_hold: got activity during pause want none"); end
    checks++; if (active_count !== 3'd1 || voice_duration[5:0] !== 6'd8) begin errors++; $display("FAIL pause_state: got cnt=%0d dur=%0d want 1/8", active_count, voice_duration[5:0]); end
    play_enable = 1'b1;
    step();
    checks++; if (voice_play_enable !== 4'b0001) begin errors++; $display("FAIL pause_resume: got %b want 0001", voice_play_enable); end
    count_active_beats(n, bad, to);
    checks++; if (to || n != 5) begin errors++; $display("FAIL pause_remaining: got %0d (timeout=%0d) want 5", n, to); end
  endtask

  task automatic test_expire_collision();
    bit ok, all_ok;
    int base, w;
    do_reset();
    while ((phase % 16) != 0) step();
    base = phase;
    all_ok = 1'b1;
    send_note(6'd1, 6'd40, ok); all_ok &= ok;
    send_note(6'd2, 6'd40, ok); all_ok &= ok;
    send_note(6'd3, 6'd1,  ok); all_ok &= ok;
    send_note(6'd4, 6'd40, ok); all_ok &= ok;
    while (phase < base + 63) step();
    checks++; if (!all_ok || voice_play_enable !== 4'b1111) begin errors++; $display("FAIL collide_fill: got ok=%0d vpe=%b want 1/1111", all_ok, voice_play_enable); end
    nif.note_valid    = 1'b1;
    nif.note_id       = 6'd9;
    nif.note_duration = 6'd40;
    checks++; if (nif.note_ready !== 1'b1) begin errors++; $display("FAIL collide_ready: got %b want 1", nif.note_ready); end
    step();
    nif.note_valid = 1'b0;
    checks++; if (steal !== 1'b1 || voice_play_enable !== 4'b1010 || active_count !== 3'd3) begin errors++; $display("FAIL collide_steal: got steal=%b vpe=%b cnt=%0d want 1/1010/3", steal, voice_play_enable, active_count); end
    w = 0;
    while (voice_start === 4'b0000 && w < 20) begin
      step();
      w++;
    end
    checks++; if (voice_start !== 4'b0001 || voice_note[5:0] !== 6'd9) begin errors++; $display("FAIL collide_target: got start=%b id=%0d want 0001/9", voice_start, voice_note[5:0]); end
  endtask

  task automatic test_reset_in_steal();
    bit ok, all_ok, bad;
    do_reset();
    all_ok = 1'b1;
    for (int k = 0; k < 5; k++) begin
      send_note(6'(30 + k), 6'd40, ok);
      all_ok &= ok;
    end
    checks++; if (!all_ok || steal !== 1'b1) begin errors++; $display("FAIL rst_steal_setup: got ok=%0d steal=%b want 1/1", all_ok, steal); end
    reset = 1'b0;
    #1;
    checks++; if (voice_play_enable !== 4'b0000 || voice_start !== 4'b0000 || steal !== 1'b0 || active_count !== 3'd0) begin errors++; $display("FAIL rst_async: got vpe=%b start=%b steal=%b cnt=%0d want all 0", voice_play_enable, voice_start, steal, active_count); end
    checks++; if (voice_note !== '0 || voice_duration !== '0 || nif.note_ready !== 1'b0) begin errors++; $display("FAIL rst_async_bus: got %h/%h ready=%b want 0/0/0", voice_note, voice_duration, nif.note_ready); end
    step();
    step();
    reset = 1'b1;
    bad = 1'b0;
    for (int c = 0; c < 30; c++) begin
      step();
      if (voice_start !== 4'b0000 || active_count !== 3'd0) bad = 1'b1;
    end
    checks++; if (bad) begin errors++; $display("FAIL rst_no_start: got start/active after release want none"); end
  endtask

  initial begin
    reset             = 1'b0;
    play_enable       = 1'b0;
    beat              = 1'b0;
    minibeat          = 1'b0;
    nif.note_valid    = 1'b0;
    nif.note_id       = '0;
    nif.note_duration = '0;
    test_reset();
    test_single_note();
    test_min_duration();
    test_steal();
    test_pause();
    test_expire_collision();
    test_reset_in_steal();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
